sound_player: RTL and testbench



---
 rtl/sound_player.sv | 100 ++++++++++
 tb/tb_sound_player.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sound_player.sv
// Note-to-tone generator: turns matcher note codes into fixed-length square-wave
// PCM tones and answers codec sample requests one cycle later.
module sound_player #(
  parameter int unsigned HALF1        = 61,
  parameter int unsigned HALF2        = 54,
  parameter int unsigned HALF3        = 48,
  parameter int unsigned HALF4        = 45,
  parameter int unsigned NOTE_SAMPLES = 16000,
  parameter logic [15:0] AMP          = 16'h2000
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [2:0]         i_sound_num,
  input  logic               i_sample_req,
  output logic signed [15:0] o_sample,
  output logic               o_sample_valid,
  output logic               o_busy,
  output logic [2:0]         o_note
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [15:0] NEG_AMP = ~AMP + 16'd1;
  localparam logic [19:0] DUR     = NOTE_SAMPLES[19:0];

  state_t      state;
  logic [2:0]  note;
  logic [15:0] half;
  logic [15:0] phase_cnt;
  logic        pol;
  logic [19:0] dur_cnt;

  logic        trig;
  logic [15:0] half_sel;

  always_comb begin
    trig     = (i_sound_num >= 3'd1) && (i_sound_num <= 3'd4);
    half_sel = 16'd0;
    case (i_sound_num)
      3'd1:    half_sel = HALF1[15:0];
      3'd2:    half_sel = HALF2[15:0];
      3'd3:    half_sel = HALF3[15:0];
      3'd4:    half_sel = HALF4[15:0];
      default: half_sel = 16'd0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state          <= IDLE;
      note           <= 3'd0;
      half           <= 16'd0;
      phase_cnt      <= 16'd0;
      pol            <= 1'b1;
      dur_cnt        <= 20'd0;
      o_sample       <= 16'sd0;
      o_sample_valid <= 1'b0;
      o_busy         <= 1'b0;
      o_note         <= 3'd0;
    end else begin
      o_sample_valid <= i_sample_req;

      if (i_sample_req) begin
        if (state == PLAY) begin
          o_sample <= $signed(pol ? AMP : NEG_AMP);
          if (phase_cnt == half - 16'd1) begin
            pol       <= ~pol;
            phase_cnt <= 16'd0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
          if (dur_cnt != 20'd0) dur_cnt <= dur_cnt - 20'd1;
          if (dur_cnt == 20'd1) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_note <= 3'd0;
          end
        end else begin
          o_sample <= 16'sd0;
        end
      end

      // Trigger is applied last so its loads win over the request's updates;
      // a repeat of the playing note only extends the tone (sustain).
      if (trig) begin
        if (state == IDLE || i_sound_num != note) begin
          note      <= i_sound_num;
          half      <= half_sel;
          phase_cnt <= 16'd0;
          pol       <= 1'b1;
        end
        dur_cnt <= DUR;
        state   <= PLAY;
        o_busy  <= 1'b1;
        o_note  <= i_sound_num;
      end
    end
  end

endmodule

// File: tb/tb_sound_player.sv
// Self-checking bench for sound_player: directed scenarios plus random traffic,
// compared cycle by cycle against a sample-index reference model.
module tb_sound_player;

  localparam int          H1 = 2, H2 = 3, H3 = 4, H4 = 5, NS = 8;
  localparam logic [15:0] A  = 16'h0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  num = 3'd0;
  logic        req = 1'b0;
  logic [15:0] sample;
  logic        valid;
  logic        busy;
  logic [2:0]  note;

  always #5 clk = ~clk;

  sound_player #(
    .HALF1(H1), .HALF2(H2), .HALF3(H3), .HALF4(H4),
    .NOTE_SAMPLES(NS), .AMP(A)
  ) dut (
    .iCLK(clk), .iRST(rst), .i_sound_num(num), .i_sample_req(req),
    .o_sample(sample), .o_sample_valid(valid), .o_busy(busy), .o_note(note)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a tone is described by its note, how many samples it has
  // already emitted (k) and how many it still owes.
  bit          m_play   = 1'b0;
  int          m_note   = 0;
  int          m_k      = 0;
  int          m_rem    = 0;
  logic [15:0] m_sample = 16'd0;
  bit          m_valid  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int half_of(input int n);
    case (n)
      1: return H1;
      2: return H2;
      3: return H3;
      default: return H4;
    endcase
  endfunction

  function automatic logic [15:0] tone_val(input int n, input int k);
    logic [15:0] neg;
    neg = ~A + 16'd1;
    return (((k / half_of(n)) % 2) == 0) ? A : neg;
  endfunction

  task automatic cycle(input logic [2:0] code, input bit r, input bit rs);
    bit was_play;
    int c;
    @(negedge clk);
    num = code;
    req = r;
    rst = rs;
    @(posedge clk);
    c = int'(code);
    if (rs) begin
      m_play = 1'b0; m_note = 0; m_k = 0; m_rem = 0;
      m_sample = 16'd0; m_valid = 1'b0;
    end else begin
      was_play = m_play;
      m_valid  = r;
      if (r) begin
        m_sample = was_play ? tone_val(m_note, m_k) : 16'd0;
        if (was_play) begin
          m_k++;
          m_rem--;
          if (m_rem == 0) m_play = 1'b0;
        end
      end
      if (c >= 1 && c <= 4) begin
        if (!was_play || c != m_note) begin
          m_note = c;
          m_k    = 0;
        end
        m_rem  = NS;
        m_play = 1'b1;
      end
    end
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("busy",  32'(busy),  32'(m_play));
    chk("note",  32'(note),  m_play ? 32'(m_note) : 32'd0);
    chk("sample", 32'(sample), 32'(m_sample));
  endtask

  task automatic req_n(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(3'd0, 1'b1, 1'b0);
      cycle(3'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    cycle(3'd0, 1'b0, 1'b1);
    cycle(3'd0, 1'b0, 1'b1);

    // idle requests return silence
    req_n(3);
    // single note 1 plays out and stops
    cycle(3'd1, 1'b0, 1'b0);
    req_n(10);
    // note change mid-tone restarts with note 2
    cycle(3'd1, 1'b0, 1'b0);
    req_n(3);
    cycle(3'd2, 1'b0, 1'b0);
    req_n(9);
    // same-note retrigger on the final request sustains
    cycle(3'd1, 1'b0, 1'b0);
    req_n(7);
    cycle(3'd1, 1'b1, 1'b0);
    cycle(3'd0, 1'b0, 1'b0);
    req_n(9);
    // invalid and zero codes are ignored
    cycle(3'd5, 1'b0, 1'b0);
    cycle(3'd0, 1'b0, 1'b0);
    cycle(3'd7, 1'b1, 1'b0);
    cycle(3'd6, 1'b0, 1'b0);
    // trigger with coincident request from idle, then back-to-back requests
    cycle(3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(3'd0, 1'b1, 1'b0);
    cycle(3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(3'd0, 1'b1, 1'b0);
    // reset mid-tone together with a request
    cycle(3'd3, 1'b0, 1'b0);
    req_n(2);
    cycle(3'd0, 1'b1, 1'b1);
    cycle(3'd0, 1'b0, 1'b0);
    req_n(1);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] code;
      bit r, rs;
      code = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      r    = ($urandom_range(0, 1) == 1);
      rs   = ($urandom_range(0, 199) == 0);
      cycle(code, r, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
